// File: rtl/uart_tx_wb.sv
// Wishbone-attached 8N1 UART transmitter: byte FIFO, status register and a
// programmable clocks-per-bit divisor driving a registered serial line.
module uart_tx_wb #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_AW     = 3,
  parameter int DEFAULT_DIV = 868
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  uart_txd,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_write,
  input  logic                  wbs_cycle,
  input  logic                  wbs_strobe,
  output logic                  wbs_ack
);
  // state | meaning
  // IDLE  | line high, pops the next byte as soon as one is queued
  // START | start bit, line low
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit, line high
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LEVEL_FULL = DEPTH[FIFO_AW:0];

  state_t state, state_next;
  logic req, push_req, push_ok, pop, load, shift_en, txd_next, tick;
  logic full, empty, ovf;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] level;
  logic [7:0] mem [DEPTH];
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [15:0] div, div_eff, cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic unused_bits;

  assign req      = wbs_cycle & wbs_strobe & ~wbs_ack;
  assign push_req = req & wbs_write & (wbs_address[1:0] == 2'd0);
  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == '0);
  // a pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push_ok  = push_req & (~full | pop);
  assign div_eff  = (div == 16'd0) ? 16'd1 : div;
  assign tick     = (cnt == 16'd0);
  assign unused_bits = &{1'b0, wbs_address, wbs_writedata};

  always_comb begin
    rdata = '0;
    case (wbs_address[1:0])
      2'd1: begin
        rdata[0] = (state != IDLE);
        rdata[1] = full;
        rdata[2] = empty;
        rdata[3] = ovf;
        rdata[4 +: FIFO_AW+1] = level;
      end
      2'd2: rdata[15:0] = div;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbs_ack      <= 1'b0;
      wbs_readdata <= '0;
      ovf          <= 1'b0;
      div          <= 16'(DEFAULT_DIV);
    end else begin
      wbs_ack      <= req;
      wbs_readdata <= (req && !wbs_write) ? rdata : '0;
      if (push_req && !push_ok)
        ovf <= 1'b1;
      else if (req && wbs_write && wbs_address[1:0] == 2'd1)
        ovf <= 1'b0;
      if (req && wbs_write && wbs_address[1:0] == 2'd2)
        div <= wbs_writedata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= wbs_writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_ok && !pop)
        level <= level + (FIFO_AW+1)'(1);
      else if (pop && !push_ok)
        level <= level - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // txd_next is the line level for the coming cycle, so the pin is a flop
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    txd_next   = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          txd_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (tick) begin
          load       = 1'b1;
          txd_next   = shift[0];
          state_next = DATA;
        end
      end
      DATA: begin
        txd_next = shift[0];
        if (tick) begin
          load = 1'b1;
          if (bit_cnt == 3'd7) begin
            txd_next   = 1'b1;
            state_next = STOP;
          end else begin
            shift_en = 1'b1;
            txd_next = shift[1];
          end
        end
      end
      STOP: begin
        if (tick)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // bit timer reloads at every bit boundary, so a new divisor waits for the next bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_txd <= 1'b1;
      cnt      <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
    end else begin
      uart_txd <= txd_next;
      if (load)
        cnt <= div_eff - 16'd1;
      else if (!tick)
        cnt <= cnt - 16'd1;
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_wb.sv
// Bench for uart_tx_wb: frame-level reference model compared every cycle,
// a serial receiver, directed scenarios and a randomized bus phase.
module tb_uart_tx_wb;
  localparam int DEFAULT_DIV = 868;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_txd;
  logic [7:0]  wbs_address = '0;
  logic [15:0] wbs_writedata = '0;
  logic [15:0] wbs_readdata;
  logic        wbs_write = 1'b0;
  logic        wbs_cycle = 1'b0;
  logic        wbs_strobe = 1'b0;
  logic        wbs_ack;

  int tests = 0;
  int fails = 0;

  uart_tx_wb #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .FIFO_AW(3), .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk(clk), .reset(reset), .uart_txd(uart_txd),
    .wbs_address(wbs_address), .wbs_writedata(wbs_writedata),
    .wbs_readdata(wbs_readdata), .wbs_write(wbs_write),
    .wbs_cycle(wbs_cycle), .wbs_strobe(wbs_strobe), .wbs_ack(wbs_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the frame currently on the line.
  byte unsigned m_q[$];
  bit          m_idle;
  int          m_bit, m_rem;
  logic [7:0]  m_cur;
  logic        m_line, m_ack, m_rd, m_ovf;
  logic [15:0] m_rdata, m_div;

  function automatic logic frame_level(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  always @(posedge clk or negedge reset) begin : model
    logic        mreq;
    logic [15:0] rv;
    int          de;
    if (!reset) begin
      m_q.delete();
      m_idle = 1; m_bit = 0; m_rem = 0; m_cur = '0;
      m_line = 1'b1; m_ack = 1'b0; m_rd = 1'b0; m_rdata = '0;
      m_div = 16'(DEFAULT_DIV); m_ovf = 1'b0;
    end else begin
      mreq = wbs_cycle & wbs_strobe & ~m_ack;
      de   = (m_div == 16'd0) ? 1 : int'(m_div);
      case (wbs_address[1:0])
        2'd1: rv = 16'(m_q.size() * 16 + (m_ovf ? 8 : 0) + (m_q.size() == 0 ? 4 : 0)
                       + (m_q.size() == 8 ? 2 : 0) + (m_idle ? 0 : 1));
        2'd2: rv = m_div;
        default: rv = 16'd0;
      endcase
      if (m_idle) begin
        if (m_q.size() > 0) begin
          m_cur  = m_q.pop_front();
          m_idle = 0; m_bit = 0; m_rem = de; m_line = 1'b0;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_bit++;
          if (m_bit == 10) begin
            m_idle = 1; m_line = 1'b1;
          end else begin
            m_rem = de; m_line = frame_level(m_cur, m_bit);
          end
        end
      end
      if (mreq && wbs_write) begin
        case (wbs_address[1:0])
          2'd0: if (m_q.size() < 8) m_q.push_back(wbs_writedata[7:0]); else m_ovf = 1'b1;
          2'd1: m_ovf = 1'b0;
          2'd2: m_div = wbs_writedata;
          default: ;
        endcase
      end
      m_rd    = mreq && !wbs_write;
      m_rdata = rv;
      m_ack   = mreq;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("txd", 32'(uart_txd), 32'(m_line));
      check("ack", 32'(wbs_ack), 32'(m_ack));
      if (m_ack && m_rd) check("rdata", 32'(wbs_readdata), 32'(m_rdata));
    end
  end

  // Serial receiver sampling mid-bit with a bench-chosen divisor.
  bit          rx_en = 0;
  int          rx_div = 2;
  byte unsigned rx_q[$];
  always begin : rx
    logic [7:0] b;
    @(negedge clk);
    if (rx_en && reset && uart_txd == 1'b0) begin
      repeat (rx_div + rx_div / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        b[k] = uart_txd;
        if (k < 7) repeat (rx_div) @(negedge clk);
      end
      repeat (rx_div) @(negedge clk);
      check("rx_stop", 32'(uart_txd), 32'd1);
      rx_q.push_back(b);
    end
  end

  task automatic wb_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    wbs_address = a; wbs_writedata = d; wbs_write = 1'b1;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1;
    @(negedge clk);
    wbs_cycle = 1'b0; wbs_strobe = 1'b0; wbs_write = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk);
    wbs_address = a; wbs_write = 1'b0;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1;
    @(negedge clk);
    d = wbs_readdata;
    wbs_cycle = 1'b0; wbs_strobe = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && rx_q.size() < n; i++) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [44:0] s;
    logic [5:0]  pat;
    int          nbad, low;
    bit          lv[10];

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_ack", 32'(wbs_ack), 32'd0);
    check("rst_rdata", 32'(wbs_readdata), 32'd0);
    reset = 1'b1;
    chk_en = 1;

    wb_read(8'd2, d);  check("div_default", 32'(d), 32'h0364);
    wb_read(8'd1, d);  check("status_reset", 32'(d), 32'h0004);
    wb_read(8'd3, d);  check("reg3_read", 32'(d), 32'h0000);

    // T1: 0x55 at 4 clocks per bit
    wb_write(8'd2, 16'd4);
    wb_write(8'd0, 16'h0055);
    lv = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    s[0] = uart_txd;
    for (int i = 1; i < 45; i++) begin
      @(negedge clk);
      s[i] = uart_txd;
    end
    nbad = (s[0] !== 1'b1) ? 1 : 0;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++)
        if (s[1 + 4*k + j] !== lv[k]) nbad++;
    for (int i = 41; i < 45; i++) if (s[i] !== 1'b1) nbad++;
    check("t1_wave_bad_samples", 32'(nbad), 32'd0);
    wb_read(8'd1, d);  check("t1_status", 32'(d), 32'h0004);

    // T2: overflow with 10 back-to-back pushes at 2 clocks per bit
    rx_div = 2; rx_q.delete(); rx_en = 1;
    wb_write(8'd2, 16'd2);
    for (int i = 0; i < 10; i++) wb_write(8'd0, 16'(i));
    wb_read(8'd1, d);  check("t2_status_full", 32'(d), 32'h008B);
    wb_write(8'd1, 16'h0000);
    wb_read(8'd1, d);  check("t2_ovf_cleared", 32'(d[3]), 32'd0);
    wait_rx(9, 400);
    check("t2_rx_count", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) check("t2_rx_byte", 32'(rx_q[i]), 32'(i));
    repeat (10) @(negedge clk);

    // T3: request held for six clocks, read then write
    rx_q.delete();
    @(negedge clk);
    wbs_address = 8'd1; wbs_write = 1'b0; wbs_cycle = 1'b1; wbs_strobe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pat[i] = wbs_ack;
      @(negedge clk);
    end
    wbs_cycle = 1'b0; wbs_strobe = 1'b0;
    check("t3_ack_pattern", 32'(pat), 32'h2A);
    @(negedge clk);
    wbs_address = 8'd0; wbs_writedata = 16'h003C; wbs_write = 1'b1;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1;
    repeat (6) @(negedge clk);
    wbs_cycle = 1'b0; wbs_strobe = 1'b0; wbs_write = 1'b0;
    wb_read(8'd1, d);  check("t3_status_two_queued", 32'(d), 32'h0021);
    wait_rx(3, 200);
    check("t3_rx_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() > 0) check("t3_rx_byte", 32'(rx_q[0]), 32'h3C);
    repeat (10) @(negedge clk);

    // T4: divisor 0 behaves as 1
    wb_write(8'd2, 16'd0);
    wb_read(8'd2, d);  check("t4_div_readback", 32'(d), 32'h0000);
    rx_div = 1; rx_q.delete();
    wb_write(8'd0, 16'h00A5);
    wait_rx(1, 50);
    check("t4_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("t4_rx_byte", 32'(rx_q[0]), 32'hA5);
    repeat (5) @(negedge clk);

    // T5: divisor change in the middle of data bit 0 of 0xF0
    rx_en = 0;
    wb_write(8'd2, 16'd8);
    wb_write(8'd0, 16'h00F0);
    low = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (uart_txd == 1'b0) low++;
          else if (low > 0) break;
        end
      end
      begin
        repeat (12) @(negedge clk);
        wb_write(8'd2, 16'd3);
      end
    join
    check("t5_low_run", 32'(low), 32'd25);
    repeat (30) @(negedge clk);

    // T6: reset during data bit 3 with three bytes queued
    wb_write(8'd2, 16'd4);
    wb_write(8'd0, 16'h0000);
    wb_write(8'd0, 16'h0011);
    wb_write(8'd0, 16'h0022);
    wb_write(8'd0, 16'h0033);
    repeat (12) @(negedge clk);
    check("t6_line_low_before", 32'(uart_txd), 32'd0);
    #2 reset = 1'b0;
    #1 check("t6_line_high_async", 32'(uart_txd), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    wb_read(8'd1, d);  check("t6_status", 32'(d), 32'h0004);
    wb_read(8'd2, d);  check("t6_div_default", 32'(d), 32'h0364);
    repeat (20) @(negedge clk);
    check("t6_line_idle", 32'(uart_txd), 32'd1);

    // Randomized bus traffic, checked cycle by cycle against the model
    wb_write(8'd2, 16'd2);
    for (int n = 0; n < 80; n++) begin
      logic [7:0] ra;
      ra = {6'($urandom), 2'd0};
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: wb_write(ra, 16'($urandom));
        5: wb_read(ra | 8'd1, d);
        6: wb_read(ra | 8'd2, d);
        7: if ($urandom_range(0, 1) == 1) wb_read(ra | 8'd3, d); else wb_read(ra, d);
        8: if ($urandom_range(0, 1) == 1) wb_write(ra | 8'd3, 16'($urandom));
           else wb_write(ra | 8'd1, 16'($urandom));
        default: wb_write(ra | 8'd2, 16'($urandom_range(0, 3)));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 3000 && !(m_idle && m_q.size() == 0); i++) @(negedge clk);
    wb_read(8'd1, d);
    check("rand_drained_status", 32'(d & 16'hFFF7), 32'h0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
